// File: rtl/instruction_fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : instruction_fetch_pkg
//  Brief    : Shared definitions for the instruction fetch stage: FSM state
//             encodings, instruction geometry and small state helpers.
//  Revision : 1.0 - initial release
// ============================================================================
package instruction_fetch_pkg;

   // Instruction geometry, matched to the instruction register downstream
   localparam int INSTR_BYTES = 3;
   localparam int BYTE_WIDTH  = 8;
   localparam int INSTR_WIDTH = INSTR_BYTES * BYTE_WIDTH;

   // Fetch FSM encodings
   typedef enum logic [2:0] {
      IF_IDLE = 3'd0,
      IF_F_OP = 3'd1,
      IF_F_A1 = 3'd2,
      IF_F_A2 = 3'd3,
      IF_LOAD = 3'd4
   } if_state_t;

   // State that follows a byte-fetch state once its byte has been acknowledged
   function automatic if_state_t next_fetch_state(input if_state_t s);
      if_state_t n;
      case (s)
         IF_F_OP: n = IF_F_A1;
         IF_F_A1: n = IF_F_A2;
         IF_F_A2: n = IF_LOAD;
         default: n = IF_IDLE;
      endcase
      return n;
   endfunction

   // Byte offset from PC that a byte-fetch state reads
   function automatic logic [1:0] byte_index(input if_state_t s);
      logic [1:0] idx;
      case (s)
         IF_F_A1: idx = 2'd1;
         IF_F_A2: idx = 2'd2;
         default: idx = 2'd0;
      endcase
      return idx;
   endfunction

endpackage
`default_nettype wire

// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : instruction_fetch
//  Brief    : Fetches three consecutive bytes (opcode, operando1, operando2)
//             from byte-wide program memory, presents them to the IR with
//             IR_load until ir_ready, then advances PC by three. Supports PC
//             redirect and a fetch enable for halt/stall.
//  Revision : 1.0 - initial release
// ============================================================================
module instruction_fetch
   import instruction_fetch_pkg::*;
#(
   parameter int                    ADDR_WIDTH = 8,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  fetch_en,
   input  logic                  pc_load,
   input  logic [ADDR_WIDTH-1:0] pc_in,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_rd,
   input  logic                  mem_ack,
   input  logic [7:0]            mem_data,
   output logic [7:0]            opcode,
   output logic [7:0]            operando1,
   output logic [7:0]            operando2,
   output logic                  IR_load,
   input  logic                  ir_ready,
   output logic [ADDR_WIDTH-1:0] pc
);

   if_state_t             state;
   if_state_t             fetch_next;
   logic [ADDR_WIDTH-1:0] pc_next;
   logic [ADDR_WIDTH-1:0] fetch_next_addr;

   // Next-PC and next-byte address; the adders wrap naturally at ADDR_WIDTH
   always_comb begin
      pc_next         = pc + ADDR_WIDTH'(INSTR_BYTES);
      fetch_next      = next_fetch_state(state);
      fetch_next_addr = pc + ADDR_WIDTH'(byte_index(fetch_next));
   end

   // Fetch FSM with registered outputs. Each byte state spends its first
   // cycle with mem_rd low (new address settling), then requests until ack.
   // LOAD likewise spends one cycle before raising IR_load. A redirect
   // overrides everything else in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IF_IDLE;
         pc        <= RESET_PC;
         mem_addr  <= '0;
         mem_rd    <= 1'b0;
         opcode    <= 8'h00;
         operando1 <= 8'h00;
         operando2 <= 8'h00;
         IR_load   <= 1'b0;
      end else if (pc_load) begin
         // Redirect: discard any partial instruction, bytes keep old values
         pc       <= pc_in;
         mem_addr <= pc_in;
         mem_rd   <= 1'b0;
         IR_load  <= 1'b0;
         state    <= fetch_en ? IF_F_OP : IF_IDLE;
      end else begin
         case (state)
            IF_IDLE: begin
               mem_rd  <= 1'b0;
               IR_load <= 1'b0;
               if (fetch_en) begin
                  mem_addr <= pc;
                  state    <= IF_F_OP;
               end
            end

            IF_F_OP, IF_F_A1, IF_F_A2: begin
               if (!mem_rd) begin
                  mem_rd <= 1'b1;
               end else if (mem_ack) begin
                  case (state)
                     IF_F_OP: opcode    <= mem_data;
                     IF_F_A1: operando1 <= mem_data;
                     default: operando2 <= mem_data;
                  endcase
                  mem_rd   <= 1'b0;
                  mem_addr <= fetch_next_addr;
                  state    <= fetch_next;
               end
            end

            IF_LOAD: begin
               if (!IR_load) begin
                  IR_load <= 1'b1;
               end else if (ir_ready) begin
                  // IR captured the instruction: step to the next one
                  IR_load  <= 1'b0;
                  pc       <= pc_next;
                  mem_addr <= pc_next;
                  state    <= fetch_en ? IF_F_OP : IF_IDLE;
               end
            end

            default: begin
               mem_rd  <= 1'b0;
               IR_load <= 1'b0;
               state   <= IF_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instruction_fetch
//  Brief    : Self-checking bench for instruction_fetch. A memory responder
//             and an IR responder generate randomized handshakes; expected
//             instructions are queued by the stimulus and checked by a
//             monitor whenever IR_load rises.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch;
   import instruction_fetch_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       fetch_en = 1'b0;
   logic       pc_load = 1'b0;
   logic [7:0] pc_in = 8'h00;
   logic [7:0] mem_addr;
   logic       mem_rd;
   logic       mem_ack = 1'b0;
   logic [7:0] mem_data = 8'h00;
   logic [7:0] opcode, operando1, operando2;
   logic       IR_load;
   logic       ir_ready = 1'b0;
   logic [7:0] pc;

   instruction_fetch #(.ADDR_WIDTH(8), .RESET_PC(8'hFE)) dut (
      .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .pc_load(pc_load),
      .pc_in(pc_in), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_ack(mem_ack),
      .mem_data(mem_data), .opcode(opcode), .operando1(operando1),
      .operando2(operando2), .IR_load(IR_load), .ir_ready(ir_ready), .pc(pc)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] pc;
      logic [7:0] op;
      logic [7:0] a1;
      logic [7:0] a2;
   } exp_t;

   logic [7:0] mem [256];
   exp_t       exp_q[$];
   logic [7:0] addr_log[$];
   int         n_cmp = 0;
   int         n_fail = 0;
   int         hs = 0;
   int         ack_mode = 0;     // 0 manual, 1 tied high, 2 random stalls
   int         ready_mode = 0;   // 0 manual, 1 tied high, 2 random stalls
   logic       man_ack = 1'b0;
   logic       man_ready = 1'b0;
   logic [7:0] man_data = 8'h00;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: an instruction at p is the three bytes at p, p+1, p+2 mod 256
   function automatic exp_t model(input logic [7:0] p);
      exp_t e;
      logic [7:0] p1, p2;
      p1 = p + 8'd1;
      p2 = p + 8'd2;
      e.pc = p;
      e.op = mem[p];
      e.a1 = mem[p1];
      e.a2 = mem[p2];
      return e;
   endfunction

   // Program memory responder
   initial begin
      int wcnt = 0;
      forever begin
         @(posedge clk);
         #2;
         case (ack_mode)
            0: begin mem_ack = man_ack; mem_data = man_data; end
            1: begin mem_ack = 1'b1; mem_data = mem[mem_addr]; end
            default: begin
               if (mem_ack) begin
                  mem_ack = 1'b0;
               end else if (mem_rd) begin
                  if (wcnt == 0) begin
                     mem_ack  = 1'b1;
                     mem_data = mem[mem_addr];
                     wcnt     = $urandom_range(0, 4);
                  end else begin
                     wcnt--;
                  end
               end
            end
         endcase
         if (mem_ack && mem_rd) addr_log.push_back(mem_addr);
      end
   end

   // Instruction register responder
   initial begin
      int rcnt = 0;
      forever begin
         @(posedge clk);
         #2;
         case (ready_mode)
            0: ir_ready = man_ready;
            1: ir_ready = 1'b1;
            default: begin
               if (ir_ready) begin
                  ir_ready = 1'b0;
                  rcnt     = $urandom_range(0, 5);
               end else if (IR_load) begin
                  if (rcnt == 0) ir_ready = 1'b1;
                  else rcnt--;
               end
            end
         endcase
      end
   end

   // Monitor / scoreboard
   initial begin
      logic       prev_load = 1'b0;
      logic       post_chk = 1'b0;
      logic [7:0] exp_after = 8'h00;
      exp_t       cur;
      cur = '{pc: 8'h00, op: 8'h00, a1: 8'h00, a2: 8'h00};
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_load = 1'b0;
            post_chk  = 1'b0;
         end else begin
            if (post_chk) begin
               check("pc_after_capture", pc, exp_after);
               check("irload_drop", IR_load, 0);
               post_chk = 1'b0;
            end
            if (IR_load && !prev_load) begin
               if (exp_q.size() == 0) begin
                  n_cmp++;
                  n_fail++;
                  $display("FAIL unexpected_instr: got pc 0x%0h expected no instruction", pc);
               end else begin
                  cur = exp_q.pop_front();
                  check("instr_pc", pc, cur.pc);
                  check("opcode", opcode, cur.op);
                  check("operando1", operando1, cur.a1);
                  check("operando2", operando2, cur.a2);
               end
            end
            if (IR_load && ir_ready && !pc_load) begin
               hs++;
               post_chk  = 1'b1;
               exp_after = cur.pc + 8'd3;
            end
            prev_load = IR_load;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_hs(input int target, input string name);
      int n = 0;
      while (hs < target && n < 400) begin tick(); n++; end
      check(name, hs, target);
   endtask

   task automatic wait_rd_addr(input logic [7:0] a, input string name);
      int n = 0;
      while (!(mem_rd && mem_addr == a) && n < 200) begin tick(); n++; end
      check(name, {mem_rd, mem_addr}, {1'b1, a});
   endtask

   task automatic do_pc_load(input logic [7:0] a, input logic en);
      pc_in    = a;
      pc_load  = 1'b1;
      fetch_en = en;
      tick();
      pc_load  = 1'b0;
      fetch_en = 1'b0;
   endtask

   // Global time bound
   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   // Stimulus
   initial begin
      int         lat;
      int         n;
      logic [7:0] start, last, q;
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      for (int i = 0; i < 6; i++) mem[i] = 8'((i + 1) * 16);
      mem[8'h40] = 8'h40;

      // Reset values
      repeat (2) @(posedge clk);
      #1;
      check("rst_mem_rd", mem_rd, 0);
      check("rst_ir_load", IR_load, 0);
      check("rst_pc", pc, 8'hFE);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_opcode", opcode, 0);
      rst_n = 1'b1;
      tick();

      // Wrap from RESET_PC = 0xFE
      ack_mode   = 2;
      ready_mode = 2;
      addr_log.delete();
      exp_q.push_back(model(8'hFE));
      fetch_en = 1'b1;
      tick();
      fetch_en = 1'b0;
      wait_hs(1, "wrap_hs");
      check("wrap_nacks", addr_log.size(), 3);
      if (addr_log.size() >= 3) begin
         check("wrap_addr0", addr_log[0], 8'hFE);
         check("wrap_addr1", addr_log[1], 8'hFF);
         check("wrap_addr2", addr_log[2], 8'h00);
      end
      tick();
      check("wrap_pc", pc, 8'h01);

      // Single-cycle memory: IR_load 7 cycles after F_OP entry
      ack_mode   = 1;
      ready_mode = 1;
      exp_q.push_back(model(8'h00));
      do_pc_load(8'h00, 1'b1);
      lat = 0;
      while (lat < 20) begin
         tick();
         lat++;
         if (IR_load) break;
      end
      check("latency", lat, 7);
      wait_hs(2, "lat_hs");
      tick();
      check("lat_pc", pc, 8'h03);

      // IR stall in LOAD
      ack_mode   = 2;
      ready_mode = 0;
      man_ready  = 1'b0;
      exp_q.push_back(model(8'h03));
      fetch_en = 1'b1;
      tick();
      fetch_en = 1'b0;
      n = 0;
      while (!IR_load && n < 100) begin tick(); n++; end
      check("stall_irload_seen", IR_load, 1);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("stall_irload", IR_load, 1);
         check("stall_opcode", opcode, mem[3]);
         check("stall_op2", operando2, mem[5]);
         check("stall_pc", pc, 8'h03);
      end
      man_ready = 1'b1;
      tick();
      man_ready = 1'b0;
      check("stall_pc_adv", pc, 8'h06);
      check("stall_irload_off", IR_load, 0);
      wait_hs(3, "stall_hs");

      // Redirect during F_A1 with a simultaneous ack
      ack_mode   = 0;
      ready_mode = 2;
      man_ack    = 1'b0;
      fetch_en   = 1'b1;
      wait_rd_addr(8'h06, "redir_fop");
      fetch_en = 1'b0;
      man_ack  = 1'b1;
      man_data = mem[6];
      tick();
      man_ack = 1'b0;
      wait_rd_addr(8'h07, "redir_fa1");
      man_ack  = 1'b1;
      man_data = mem[7];
      pc_in    = 8'h40;
      pc_load  = 1'b1;
      fetch_en = 1'b1;
      exp_q.push_back(model(8'h40));
      tick();
      pc_load  = 1'b0;
      fetch_en = 1'b0;
      man_ack  = 1'b0;
      addr_log.delete();
      check("redir_mem_rd", mem_rd, 0);
      check("redir_irload", IR_load, 0);
      check("redir_pc", pc, 8'h40);
      check("redir_addr", mem_addr, 8'h40);
      ack_mode = 2;
      wait_hs(4, "redir_hs");
      check("redir_first_req", (addr_log.size() > 0) ? int'(addr_log[0]) : -1, 8'h40);

      // Random segments with random stalls; fetch_en dropped in F_A2 of last
      for (int seg = 0; seg < 5; seg++) begin
         int base;
         int cnt;
         start = (seg == 0) ? 8'hFD : 8'($urandom);
         cnt   = $urandom_range(2, 5);
         do_pc_load(start, 1'b0);
         base = hs;
         for (int k = 0; k < cnt; k++) begin
            q = start + 8'(k * INSTR_BYTES);
            exp_q.push_back(model(q));
         end
         last       = start + 8'((cnt - 1) * INSTR_BYTES);
         ack_mode   = 2;
         ready_mode = 2;
         fetch_en   = 1'b1;
         wait_hs(base + cnt - 1, "seg_hs_pre");
         wait_rd_addr(last + 8'd2, "seg_last_fa2");
         fetch_en = 1'b0;
         wait_hs(base + cnt, "seg_hs");
         repeat (4) tick();
         check("seg_idle_rd", mem_rd, 0);
         check("seg_idle_irload", IR_load, 0);
         check("seg_end_pc", pc, 8'(start + 8'(cnt * INSTR_BYTES)));
      end

      // Asynchronous reset in the middle of F_A1
      do_pc_load(8'h80, 1'b1);
      wait_rd_addr(8'h81, "rst_fa1");
      #3;
      rst_n = 1'b0;
      #1;
      check("arst_mem_rd", mem_rd, 0);
      check("arst_irload", IR_load, 0);
      check("arst_pc", pc, 8'hFE);
      check("arst_opcode", opcode, 0);
      ack_mode   = 0;
      ready_mode = 0;
      man_ack    = 1'b0;
      man_ready  = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (3) tick();
      check("arst_idle_rd", mem_rd, 0);
      check("queue_drained", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
